// File: rtl/fp16_pkg.sv
// fp16_pkg: fp16 field layout, special encodings and converter FSM states.
package fp16_pkg;
  localparam int SIGN_BIT = 15;
  localparam int EXP_W = 5;
  localparam int MANT_W = 10;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX_INT = 30;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/int_to_fp_converter_if.sv
// int_to_fp_converter_if: operand/result valid-ready handshake bundle.
interface int_to_fp_converter_if;
  logic in_valid;
  logic in_ready;
  logic [15:0] x;
  logic out_valid;
  logic out_ready;
  logic [15:0] r;
  logic negative;
  logic zero;
  logic inexact;
  modport master (output in_valid, x, out_ready, input in_ready, out_valid, r, negative, zero, inexact);
  modport slave (input in_valid, x, out_ready, output in_ready, out_valid, r, negative, zero, inexact);
endinterface

// File: rtl/fp16_round_pack.sv
// fp16_round_pack: rounds a normalised magnitude (leading one implicit) and packs the fp16 word.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  exponent,
  input  logic [14:0]       mag,
  input  logic              round_nearest,
  output logic [15:0]       r,
  output logic              inexact
);
  logic [MANT_W-1:0] mant;
  logic guard, sticky, up;
  logic [MANT_W:0] sum;
  always_comb begin
    mant = mag[14:5];
    guard = mag[4];
    sticky = |mag[3:0];
    up = round_nearest & guard & (sticky | mant[0]);
    sum = {1'b0, mant} + {{MANT_W{1'b0}}, up};
    inexact = guard | sticky;
    // a mantissa carry-out leaves sum[9:0] at zero and bumps the exponent
    r = {sign, exponent + {{(EXP_W-1){1'b0}}, sum[MANT_W]}, sum[MANT_W-1:0]};
  end
endmodule

// File: rtl/int_to_fp_converter.sv
// int_to_fp_converter: iterative signed int16 to fp16 conversion, one normalising shift per cycle.
module int_to_fp_converter
  import fp16_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b1,
  parameter int EXP_BIAS = fp16_pkg::EXP_BIAS
) (
  input logic clk,
  input logic rst_n,
  int_to_fp_converter_if.slave bus
);
  state_t state;
  logic sign;
  logic [15:0] mag;
  logic [EXP_W-1:0] expo;
  logic [15:0] rp_r;
  logic rp_inexact;
  assign bus.in_ready = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  fp16_round_pack u_round_pack (
    .sign(sign),
    .exponent(expo),
    .mag(mag[14:0]),
    .round_nearest(ROUND_NEAREST),
    .r(rp_r),
    .inexact(rp_inexact)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sign <= 1'b0;
      mag <= '0;
      expo <= '0;
      bus.r <= FP16_ZERO;
      bus.negative <= 1'b0;
      bus.zero <= 1'b0;
      bus.inexact <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          sign <= bus.x[15];
          mag <= bus.x[15] ? -bus.x : bus.x;
          // exponent for a leading one already at bit 15
          expo <= EXP_W'(EXP_BIAS + SIGN_BIT);
          if (bus.x == '0) begin
            bus.r <= FP16_ZERO;
            bus.negative <= 1'b0;
            bus.zero <= 1'b1;
            bus.inexact <= 1'b0;
            state <= DONE;
          end else state <= NORM;
        end
        NORM: if (mag[15]) state <= ROUND;
        else begin
          mag <= mag << 1;
          expo <= expo - 1'b1;
        end
        ROUND: begin
          bus.r <= rp_r;
          bus.negative <= sign;
          bus.zero <= 1'b0;
          bus.inexact <= rp_inexact;
          state <= DONE;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/int_to_fp_converter.md
Name: int_to_fp_converter

Overview:
- Iterative signed 16-bit integer to IEEE-754 half-precision (fp16) converter.
- Sits directly upstream of the fp16-to-int converter in the ALU datapath. It produces the fp16 operands that the fp16-to-int converter and the FP unit consume.
- Normalises by shifting one bit per cycle, then rounds and packs.
- Uses valid/ready handshakes on both sides. Accepts one conversion at a time.

Parameters:
- ROUND_NEAREST, 1, 1 = round-to-nearest-even; 0 = truncate toward zero.
- EXP_BIAS, 15, fp16 exponent bias. Fixed for fp16; must not be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  x is valid.
- in_ready  output  1  block can accept x.
- x  input  16  two's-complement integer operand.
- out_valid  output  1  r and flags are valid.
- out_ready  input  1  downstream accepts r.
- r  output  16  fp16 result: sign[15], exponent[14:10], mantissa[9:0].
- negative  output  1  r[15].
- zero  output  1  r == 16'h0000.
- inexact  output  1  rounding or truncation discarded nonzero bits.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, r=0, negative=0, zero=0, inexact=0. Reset mid-operation discards the in-flight conversion.
- Registered state: state, sign, mag[15:0], exp[4:0]. r and flags are registered outputs.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are driven combinationally from state.
- IDLE: on in_valid, capture the operand:
  - sign = x[15].
  - mag = sign ? -x : x. -32768 gives mag=0x8000, unsigned, with no overflow.
  - exp = 30.
  - If x==0, load r=0, zero=1, inexact=0, and go to DONE (latency 1 cycle).
  - Otherwise go to NORM.
- NORM:
  - If mag[15]==0: mag <= mag<<1, exp <= exp-1, stay in NORM.
  - If mag[15]==1: go to ROUND, with no shift that cycle.
  - Maximum 15 shift cycles (x=±1). exp never drops below 15.
- ROUND (combinational round/pack, registered into r):
  - mant = mag[14:5], guard = mag[4], sticky = |mag[3:0].
  - If ROUND_NEAREST=1: round up when guard & (sticky | mant[0]).
  - If ROUND_NEAREST=0: never round up.
  - If mant is 0x3FF and rounds up: mant=0, exp=exp+1. Maximum reachable exp is 30, so inf/NaN is never produced.
  - r = {sign, exp, mant}. inexact = guard | sticky. negative = sign. zero = 0.
  - Go to DONE.
- DONE: hold r and flags stable while out_ready=0. On out_ready=1, go to IDLE. in_ready stays 0 in DONE, so the earliest new accept is the cycle after the handoff.
- in_valid while busy is ignored, because in_ready is 0. x only needs to be stable in the accept cycle.
- Latency for x≠0, from accept edge to out_valid: 2 + lz cycles, where lz = leading zeros of mag (0..15).
  - Example x=-32768: 2 cycles.
  - Example x=1: 17 cycles.
- x changing after the accept edge has no effect.

Decomposition:
- Shared package fp16_pkg holds:
  - field widths: SIGN_BIT=15, EXP_W=5, MANT_W=10;
  - EXP_BIAS=15, EXP_MAX_INT=30;
  - state enum {IDLE, NORM, ROUND, DONE};
  - special constants FP16_ZERO=16'h0000, FP16_POS_INF=16'h7C00.
  The fp16-to-int converter reuses the same field constants.
- One natural sub-module, fp16_round_pack: combinational, takes (sign, exp, mag[14:0], round_nearest) and returns (r, inexact). The FSM, shifter and handshake stay in the top.

Test Plan:
- x=1 → r=0x3C00, inexact=0, negative=0, out_valid 17 cycles after accept.
- x=-1 → r=0xBC00, negative=1. x=1024 → r=0x6400, exact.
- x=0 → r=0x0000, zero=1, out_valid 1 cycle after accept. x=-32768 → r=0xF800, 2-cycle latency.
- Ties and carry:
  - x=2049 → r=0x6800, inexact=1 (tie to even, no round-up).
  - x=2051 → r=0x6802 (tie rounds up).
  - x=32767 → r=0x7800 (mantissa carry into exponent).
  - With ROUND_NEAREST=0: 2051 → 0x6801, 32767 → 0x77FF.
- Backpressure:
  - Hold out_ready=0 for 5 cycles → r and flags stable, in_ready=0.
  - Pulse in_valid with a new x during busy → ignored.
  - Release out_ready → IDLE next cycle, new x accepted.
- Assert rst_n=0 during NORM for x=1 → all outputs return to reset values immediately. After release, x=3 converts cleanly to 0x4200.
